// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module : rand_range_sampler
// Turns raw rand_gen words into a uniform value in [0, LIMIT-1] by rejection
// sampling, with an optional no-immediate-repeat rule and bounded fallback.
// Rev    : 1.0  initial release
// ============================================================================
module rand_range_sampler #(
  parameter int W         = 5,
  parameter int LIMIT     = 20,
  parameter int MAX_TRIES = 8,
  parameter int NO_REPEAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  output logic         rnd_en,
  input  logic [W-1:0] rnd,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] value,
  output logic         fallback
);

  localparam logic [W:0]   c_limit     = (W+1)'(LIMIT);
  localparam logic [W-1:0] c_limit_m1  = W'(LIMIT - 1);
  localparam logic [8:0]   c_max_tries = 9'(MAX_TRIES);
  localparam bit           c_chk_rep   = (NO_REPEAT != 0) && (LIMIT > 1);

  // Encoding keeps STEP as the only state with bit 0 set, so rnd_en is a flop.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STEP   = 2'b01,
    SAMPLE = 2'b10
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [7:0]   r_tries;
  logic [W-1:0] r_last;
  logic         r_have_last;
  logic [W-1:0] r_value;
  logic         r_valid;
  logic         r_fallback;

  logic         w_in_range;
  logic         w_is_repeat;
  logic         w_accept;
  logic         w_more;
  logic [W-1:0] w_mod;
  logic [W-1:0] w_mod_inc;
  logic [W-1:0] w_fb_val;
  logic         w_deliver;
  logic         w_fb;
  logic         w_retry;
  logic         w_start;

  assign w_in_range  = ({1'b0, rnd} < c_limit);
  assign w_is_repeat = c_chk_rep && r_have_last && (rnd == r_last);
  assign w_accept    = w_in_range && !w_is_repeat;
  assign w_more      = (({1'b0, r_tries}) + 9'd1) < c_max_tries;

  assign w_mod     = W'({1'b0, rnd} % c_limit);
  assign w_mod_inc = (w_mod == c_limit_m1) ? '0 : w_mod + 1'b1;
  assign w_fb_val  = (c_chk_rep && r_have_last && (w_mod == r_last)) ? w_mod_inc : w_mod;

  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    w_fb        = 1'b0;
    w_retry     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_start     = 1'b1;
          w_state_nxt = STEP;
        end
      end
      STEP: w_state_nxt = SAMPLE;
      SAMPLE: begin
        if (w_accept) begin
          w_deliver   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_more) begin
          w_retry     = 1'b1;
          w_state_nxt = STEP;
        end else begin
          w_deliver   = 1'b1;
          w_fb        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tries     <= '0;
      r_last      <= '0;
      r_have_last <= 1'b0;
      r_value     <= '0;
      r_valid     <= 1'b0;
      r_fallback  <= 1'b0;
    end else begin
      r_valid <= w_deliver;
      if (w_start) begin
        r_tries <= '0;
      end else if (w_retry) begin
        r_tries <= r_tries + 8'd1;
      end
      if (w_deliver) begin
        r_value     <= w_fb ? w_fb_val : rnd;
        r_last      <= w_fb ? w_fb_val : rnd;
        r_have_last <= 1'b1;
        r_fallback  <= w_fb;
      end
    end
  end

  assign rnd_en   = r_state[0];
  assign busy     = (r_state != IDLE);
  assign valid    = r_valid;
  assign value    = r_value;
  assign fallback = r_fallback;

endmodule
`default_nettype wire
